// File: rtl/ysyx_22050710_axil_slave_wrap.sv
// AXI4-Lite responder bridging to a synchronous-SRAM style memory port.
// Independent read and write FSMs; out-of-window accesses answer DECERR without touching memory.
module ysyx_22050710_axil_slave_wrap #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE  = 32'h0800_0000
) (
    input  logic                  i_aclk,
    input  logic                  i_arsetn,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [2:0]            i_awprot,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic [1:0]            o_bresp,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [2:0]            i_arprot,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_mem_ren,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [STRB_WIDTH-1:0] o_mem_wstrb
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_MEM, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} w_state_t;

    // One bit of headroom so that neither the subtraction nor the compare can wrap.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] a;
        logic [ADDR_WIDTH:0] base;
        logic [ADDR_WIDTH:0] off;
        a    = {1'b0, addr};
        base = {1'b0, ADDR_BASE};
        off  = a - base;
        return (a >= base) && (off < {1'b0, ADDR_SIZE});
    endfunction

    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    w_state_t              w_state_q, w_state_d;
    logic                  aw_got_q, aw_got_d;
    logic                  w_got_q, w_got_d;
    logic                  aw_ok_q, aw_ok_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    logic aw_fire;
    logic w_fire;
    logic unused_prot;

    assign unused_prot = ^{i_awprot, i_arprot};

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (i_arvalid) begin
                    araddr_d = i_araddr - ADDR_BASE;
                    if (addr_in_range(i_araddr)) begin
                        r_state_d = R_MEM;
                    end else begin
                        r_state_d = R_RESP;
                        rresp_d   = RESP_DECERR;
                        rdata_d   = '0;
                    end
                end
            end
            R_MEM:  r_state_d = R_WAIT;
            R_WAIT: begin
                rdata_d   = i_mem_rdata;
                rresp_d   = RESP_OKAY;
                r_state_d = R_RESP;
            end
            R_RESP: if (i_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // AW and W may arrive in either order; the pair completes on the later fire.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_ok_d   = aw_ok_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_fire = i_awvalid & ~aw_got_q;
                w_fire  = i_wvalid & ~w_got_q;
                if (aw_fire) begin
                    aw_got_d = 1'b1;
                    awaddr_d = i_awaddr - ADDR_BASE;
                    aw_ok_d  = addr_in_range(i_awaddr);
                end
                if (w_fire) begin
                    w_got_d = 1'b1;
                    wdata_d = i_wdata;
                    wstrb_d = i_wstrb;
                end
                if ((aw_got_q | aw_fire) && (w_got_q | w_fire)) begin
                    if (aw_ok_d) begin
                        w_state_d = W_MEM;
                    end else begin
                        w_state_d = W_RESP;
                        bresp_d   = RESP_DECERR;
                    end
                end
            end
            W_MEM: begin
                w_state_d = W_RESP;
                bresp_d   = RESP_OKAY;
            end
            W_RESP: begin
                if (i_bready) begin
                    w_state_d = W_IDLE;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_ok_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            aw_ok_q   <= aw_ok_d;
            bresp_q   <= bresp_d;
        end
    end

    // Payload registers are only consumed behind the control flags, so they need no reset.
    always_ff @(posedge i_aclk) begin
        araddr_q <= araddr_d;
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    assign o_arready   = i_arsetn & (r_state_q == R_IDLE);
    assign o_rvalid    = i_arsetn & (r_state_q == R_RESP);
    assign o_rdata     = rdata_q;
    assign o_rresp     = rresp_q;
    assign o_mem_ren   = i_arsetn & (r_state_q == R_MEM);
    assign o_mem_raddr = araddr_q;

    assign o_awready   = i_arsetn & (w_state_q == W_IDLE) & ~aw_got_q;
    assign o_wready    = i_arsetn & (w_state_q == W_IDLE) & ~w_got_q;
    assign o_bvalid    = i_arsetn & (w_state_q == W_RESP);
    assign o_bresp     = bresp_q;
    assign o_mem_wen   = i_arsetn & (w_state_q == W_MEM);
    assign o_mem_waddr = awaddr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_ysyx_22050710_axil_slave_wrap.sv
// Scoreboard bench for the AXI-Lite responder: expectations are queued when stimulus is
// driven and popped by a monitor when the memory port or response channels produce output.
module tb_ysyx_22050710_axil_slave_wrap;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wexp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    r;
    } rexp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_awvalid = 1'b0;
    logic [AW-1:0] i_awaddr = '0;
    logic [2:0]    i_awprot = 3'b000;
    logic          i_wvalid = 1'b0;
    logic [DW-1:0] i_wdata = '0;
    logic [SW-1:0] i_wstrb = '0;
    logic          i_bready = 1'b1;
    logic          i_arvalid = 1'b0;
    logic [AW-1:0] i_araddr = '0;
    logic [2:0]    i_arprot = 3'b000;
    logic          i_rready = 1'b1;
    logic [DW-1:0] mem_rdata = '0;

    logic          o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]    o_bresp, o_rresp;
    logic [DW-1:0] o_rdata, o_mem_wdata;
    logic          o_mem_ren, o_mem_wen;
    logic [AW-1:0] o_mem_raddr, o_mem_waddr;
    logic [SW-1:0] o_mem_wstrb;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    wexp_t         exp_w[$];
    rexp_t         exp_r[$];
    logic [1:0]    exp_b[$];
    logic [AW-1:0] exp_ra[$];
    int            wen_cyc[$];
    int            ren_cyc[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    ysyx_22050710_axil_slave_wrap dut (
        .i_aclk(clk), .i_arsetn(rst_n),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awprot(i_awprot),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arprot(i_arprot),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_mem_ren(o_mem_ren), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(mem_rdata),
        .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
        .o_mem_wstrb(o_mem_wstrb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_mem_ren) mem_rdata <= mem.exists(o_mem_raddr) ? mem[o_mem_raddr] : '0;
    end

    // Monitor: pops the scoreboard whenever the DUT produces memory traffic or a response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_mem_ren) begin
                ren_cyc.push_back(cyc);
                checks++;
                if (exp_ra.size() == 0) begin
                    $display("FAIL mem_ren: unexpected pulse raddr=%h", o_mem_raddr);
                end else begin
                    logic [AW-1:0] ea;
                    ea = exp_ra.pop_front();
                    if (o_mem_raddr !== ea) $display("FAIL mem_raddr: got %h want %h", o_mem_raddr, ea);
                    else passes++;
                end
            end
            if (o_mem_wen) begin
                wen_cyc.push_back(cyc);
                checks++;
                if (exp_w.size() == 0) begin
                    $display("FAIL mem_wen: unexpected pulse waddr=%h", o_mem_waddr);
                end else begin
                    wexp_t ew;
                    ew = exp_w.pop_front();
                    if (o_mem_waddr !== ew.a || o_mem_wdata !== ew.d || o_mem_wstrb !== ew.s)
                        $display("FAIL mem_write: got %h/%h/%h want %h/%h/%h",
                                 o_mem_waddr, o_mem_wdata, o_mem_wstrb, ew.a, ew.d, ew.s);
                    else passes++;
                end
            end
            if (o_rvalid && i_rready) begin
                checks++;
                if (exp_r.size() == 0) begin
                    $display("FAIL rresp: unexpected response data=%h", o_rdata);
                end else begin
                    rexp_t er;
                    er = exp_r.pop_front();
                    if (o_rdata !== er.d || o_rresp !== er.r)
                        $display("FAIL read_resp: got %h/%b want %h/%b", o_rdata, o_rresp, er.d, er.r);
                    else passes++;
                end
            end
            if (o_bvalid && i_bready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    $display("FAIL bresp: unexpected response %b", o_bresp);
                end else begin
                    logic [1:0] eb;
                    eb = exp_b.pop_front();
                    if (o_bresp !== eb) $display("FAIL write_resp: got %b want %b", o_bresp, eb);
                    else passes++;
                end
            end
        end
    end

    // Drive AW and W together and hold each until accepted; lat = cycles waited, -1 on timeout.
    task automatic send_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] strb, output int lat);
        logic a, w;
        lat = -1;
        i_awaddr = addr; i_wdata = data; i_wstrb = strb;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            a = o_awready; w = o_wready;
            @(posedge clk); #1;
            if (a) i_awvalid = 1'b0;
            if (w) i_wvalid = 1'b0;
            if (!i_awvalid && !i_wvalid) begin
                lat = n;
                break;
            end
        end
        i_awvalid = 1'b0; i_wvalid = 1'b0;
    endtask

    task automatic send_read(input logic [AW-1:0] addr, output int lat);
        logic a;
        lat = -1;
        i_araddr = addr; i_arvalid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            a = o_arready;
            @(posedge clk); #1;
            if (a) begin
                lat = n;
                break;
            end
        end
        i_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 40; n++) begin
            if (exp_w.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0 && exp_ra.size() == 0)
                break;
            @(posedge clk); #1;
        end
        checks++;
        if (exp_w.size() + exp_r.size() + exp_b.size() + exp_ra.size() != 0)
            $display("FAIL %s drain: pending w=%0d r=%0d b=%0d ra=%0d want all 0", tag,
                     exp_w.size(), exp_r.size(), exp_b.size(), exp_ra.size());
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_arready, o_awready, o_wready, o_rvalid, o_bvalid, o_mem_ren, o_mem_wen} !== 7'b0)
            $display("FAIL reset_outputs: got %b want 0000000",
                     {o_arready, o_awready, o_wready, o_rvalid, o_bvalid, o_mem_ren, o_mem_wen});
        else passes++;
        checks++;
        if (o_rdata !== '0 || o_rresp !== 2'b00 || o_bresp !== 2'b00)
            $display("FAIL reset_regs: got %h/%b/%b want 0/00/00", o_rdata, o_rresp, o_bresp);
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_arready, o_awready, o_wready} !== 3'b111)
            $display("FAIL reset_release_ready: got %b want 111", {o_arready, o_awready, o_wready});
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_write_same_cycle();
        exp_w.push_back('{a: 32'h10, d: 64'hDEAD_BEEF_0123_4567, s: 8'hFF});
        exp_b.push_back(2'b00);
        i_awaddr = 32'h8000_0010; i_wdata = 64'hDEAD_BEEF_0123_4567; i_wstrb = 8'hFF;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_awready, o_wready} !== 2'b11)
            $display("FAIL wr_same_ready: got %b want 11", {o_awready, o_wready});
        else passes++;
        @(posedge clk); #1;
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_mem_wen, o_bvalid, o_awready} !== 3'b100)
            $display("FAIL wr_same_k1: wen/bvalid/awready got %b want 100", {o_mem_wen, o_bvalid, o_awready});
        else passes++;
        @(negedge clk);
        checks++;
        if ({o_mem_wen, o_bvalid} !== 2'b01 || o_bresp !== 2'b00)
            $display("FAIL wr_same_k2: wen/bvalid got %b bresp %b want 01 00", {o_mem_wen, o_bvalid}, o_bresp);
        else passes++;
        @(negedge clk);
        checks++;
        if ({o_awready, o_wready, o_bvalid} !== 3'b110)
            $display("FAIL wr_same_b2b_ready: got %b want 110", {o_awready, o_wready, o_bvalid});
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_w_before_aw();
        exp_w.push_back('{a: 32'h100, d: 64'hA5A5_5A5A_0F0F_F0F0, s: 8'h0F});
        exp_b.push_back(2'b00);
        i_wdata = 64'hA5A5_5A5A_0F0F_F0F0; i_wstrb = 8'h0F; i_wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        i_wvalid = 1'b0; i_wdata = 64'h0BAD_0BAD_0BAD_0BAD; i_wstrb = 8'hF0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if ({o_wready, o_awready, o_mem_wen, o_bvalid} !== 4'b0100)
                $display("FAIL w_first_hold%0d: wready/awready/wen/bvalid got %b want 0100", n,
                         {o_wready, o_awready, o_mem_wen, o_bvalid});
            else passes++;
            @(posedge clk); #1;
        end
        i_awaddr = 32'h8000_0100; i_awvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        i_awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_mem_wen !== 1'b1) $display("FAIL w_first_wen: got %b want 1", o_mem_wen);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_bvalid !== 1'b1) $display("FAIL w_first_bvalid: got %b want 1", o_bvalid);
        else passes++;
        @(posedge clk); #1;
        wait_drain("w_first");
    endtask

    task automatic test_read();
        logic [DW-1:0] d = 64'h1122_3344_5566_7788;
        mem[32'h10] = d;
        exp_ra.push_back(32'h10);
        exp_r.push_back('{d: d, r: 2'b00});
        i_rready = 1'b0;
        i_araddr = 32'h8000_0010; i_arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        i_arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_mem_ren, o_arready} !== 2'b10)
            $display("FAIL rd_k1: ren/arready got %b want 10", {o_mem_ren, o_arready});
        else passes++;
        @(negedge clk);
        checks++;
        if (o_rvalid !== 1'b0) $display("FAIL rd_k2_rvalid: got %b want 0", o_rvalid);
        else passes++;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (o_rvalid !== 1'b1 || o_rdata !== d || o_rresp !== 2'b00)
                $display("FAIL rd_hold%0d: got %b/%h/%b want 1/%h/00", n, o_rvalid, o_rdata, o_rresp, d);
            else passes++;
        end
        @(posedge clk); #1;
        i_rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({o_arready, o_rvalid} !== 2'b10)
            $display("FAIL rd_b2b_ready: arready/rvalid got %b want 10", {o_arready, o_rvalid});
        else passes++;
        @(posedge clk); #1;
        wait_drain("read");
    endtask

    task automatic test_decerr();
        int lat;
        exp_r.push_back('{d: '0, r: 2'b11});
        send_read(32'h7FFF_FFF8, lat);
        @(negedge clk);
        checks++;
        if (lat < 0 || o_rvalid !== 1'b1 || o_rdata !== '0 || o_rresp !== 2'b11)
            $display("FAIL rd_decerr: lat %0d got %b/%h/%b want 1/0/11", lat, o_rvalid, o_rdata, o_rresp);
        else passes++;
        @(posedge clk); #1;
        exp_b.push_back(2'b11);
        send_write(32'h8800_0000, 64'h1, 8'hFF, lat);
        @(negedge clk);
        checks++;
        if (lat < 0 || o_bvalid !== 1'b1 || o_bresp !== 2'b11)
            $display("FAIL wr_decerr: lat %0d got %b/%b want 1/11", lat, o_bvalid, o_bresp);
        else passes++;
        @(posedge clk); #1;
        exp_w.push_back('{a: 32'h07FF_FFF8, d: 64'h0123_4567_89AB_CDEF, s: 8'h81});
        exp_b.push_back(2'b00);
        send_write(32'h87FF_FFF8, 64'h0123_4567_89AB_CDEF, 8'h81, lat);
        @(negedge clk);
        checks++;
        if (lat < 0 || o_mem_wen !== 1'b1 || o_bvalid !== 1'b0)
            $display("FAIL wr_top_edge: lat %0d wen/bvalid got %b want 10", lat, {o_mem_wen, o_bvalid});
        else passes++;
        @(posedge clk); #1;
        mem[32'h0] = 64'hCAFE_F00D_0000_0001;
        exp_ra.push_back(32'h0);
        exp_r.push_back('{d: 64'hCAFE_F00D_0000_0001, r: 2'b00});
        send_read(32'h8000_0000, lat);
        exp_r.push_back('{d: '0, r: 2'b11});
        send_read(32'h8800_0000, lat);
        wait_drain("decerr");
    endtask

    task automatic test_concurrent();
        mem[32'h20] = 64'h0F1E_2D3C_4B5A_6978;
        exp_ra.push_back(32'h20);
        exp_r.push_back('{d: 64'h0F1E_2D3C_4B5A_6978, r: 2'b00});
        exp_w.push_back('{a: 32'h30, d: 64'h5555_AAAA_5555_AAAA, s: 8'h3C});
        exp_b.push_back(2'b00);
        i_araddr = 32'h8000_0020; i_awaddr = 32'h8000_0030;
        i_wdata = 64'h5555_AAAA_5555_AAAA; i_wstrb = 8'h3C;
        i_arvalid = 1'b1; i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_arready, o_awready, o_wready} !== 3'b111)
            $display("FAIL conc_ready: got %b want 111", {o_arready, o_awready, o_wready});
        else passes++;
        @(posedge clk); #1;
        i_arvalid = 1'b0; i_awvalid = 1'b0; i_wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_mem_ren, o_mem_wen} !== 2'b11)
            $display("FAIL conc_strobes: ren/wen got %b want 11", {o_mem_ren, o_mem_wen});
        else passes++;
        @(posedge clk); #1;
        wait_drain("concurrent");
    endtask

    task automatic test_back_to_back();
        int lat;
        wen_cyc.delete();
        ren_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            logic [SW-1:0] s;
            s = (i == 1) ? 8'h00 : 8'hFF;
            exp_w.push_back('{a: 32'h200 + 8 * i, d: 64'h1000 + i, s: s});
            exp_b.push_back(2'b00);
            send_write(32'h8000_0200 + 8 * i, 64'h1000 + i, s, lat);
        end
        wait_drain("b2b_write");
        checks++;
        if (wen_cyc.size() != 3 || wen_cyc[1] - wen_cyc[0] != 3 || wen_cyc[2] - wen_cyc[1] != 3)
            $display("FAIL b2b_write_gap: pulses %0d gaps %0d,%0d want 3 pulses gaps 3,3", wen_cyc.size(),
                     wen_cyc.size() > 1 ? wen_cyc[1] - wen_cyc[0] : -1,
                     wen_cyc.size() > 2 ? wen_cyc[2] - wen_cyc[1] : -1);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            mem[32'h300 + 8 * i] = 64'hBEEF_0000 + i;
            exp_ra.push_back(32'h300 + 8 * i);
            exp_r.push_back('{d: 64'hBEEF_0000 + i, r: 2'b00});
            send_read(32'h8000_0300 + 8 * i, lat);
        end
        wait_drain("b2b_read");
        checks++;
        if (ren_cyc.size() != 3 || ren_cyc[1] - ren_cyc[0] != 4 || ren_cyc[2] - ren_cyc[1] != 4)
            $display("FAIL b2b_read_gap: pulses %0d gaps %0d,%0d want 3 pulses gaps 4,4", ren_cyc.size(),
                     ren_cyc.size() > 1 ? ren_cyc[1] - ren_cyc[0] : -1,
                     ren_cyc.size() > 2 ? ren_cyc[2] - ren_cyc[1] : -1);
        else passes++;
    endtask

    task automatic test_reset_abort();
        int lat;
        bit seen = 1'b0;
        mem[32'h40] = 64'h7777_6666_5555_4444;
        exp_ra.push_back(32'h40);
        i_rready = 1'b0;
        send_read(32'h8000_0040, lat);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (o_rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) $display("FAIL abort_rvalid_seen: got 0 want 1");
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rvalid, o_arready, o_mem_ren, o_bvalid} !== 4'b0000)
            $display("FAIL abort_drop: rvalid/arready/ren/bvalid got %b want 0000",
                     {o_rvalid, o_arready, o_mem_ren, o_bvalid});
        else passes++;
        i_rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_rvalid, o_arready} !== 2'b01)
            $display("FAIL abort_release: rvalid/arready got %b want 01", {o_rvalid, o_arready});
        else passes++;
        @(posedge clk); #1;
        mem[32'h48] = 64'h0102_0304_0506_0708;
        exp_ra.push_back(32'h48);
        exp_r.push_back('{d: 64'h0102_0304_0506_0708, r: 2'b00});
        send_read(32'h8000_0048, lat);
        wait_drain("after_abort");
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read();
        test_decerr();
        test_concurrent();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
